alap_dp_arbiter: RTL and testbench

Shares one ALAP scheduled datapath (go/done control unit plus datapath) between N_REQ independent requesters. Round-robin arbitration picks a requester and latches its two operands. The block then pulses go and waits for done, with a watchdog timeout. The captured result, or an error, is returned to the granted requester through a valid/ready response handshake. It sits between the client ports and the datapath's go/in0/in1/done/result interface.

---
 rtl/alap_dp_arbiter.sv | 132 +++++++++++++
 tb/tb_alap_dp_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alap_dp_arbiter.sv
// alap_dp_arbiter
//   Shares one go/done scheduled datapath between N_REQ requesters.
//   A round-robin selector picks a requester in IDLE and latches its
//   operands. The block pulses dp_go, waits for dp_done under a watchdog,
//   then returns the result (or a timeout error) on a per-requester
//   valid/ready response channel.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot, IDLE only)
//   req_a/req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   per-requester response handshake (valid one-hot)
//   rsp_data/rsp_err      response payload; err=1 means watchdog abort, data=0
//   dp_go                 one-cycle start pulse to the datapath
//   dp_in0/dp_in1         registered operands, held until the next grant
//   dp_done/dp_result     datapath completion pulse and result
//   busy                  1 in any state other than IDLE
//   grant_id              current or last granted requester
module alap_dp_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16,
   localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic                   dp_go,
   output logic [WIDTH-1:0]       dp_in0,
   output logic [WIDTH-1:0]       dp_in1,
   input  logic                   dp_done,
   input  logic [WIDTH-1:0]       dp_result,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [CW-1:0]    cnt;
   logic [IDW-1:0]   sel;
   logic             sel_vld;
   logic [WIDTH-1:0] a_arr [N_REQ];
   logic [WIDTH-1:0] b_arr [N_REQ];

   // Unpack operands and decode the one-hot handshake outputs per requester.
   // req_ready is gated by rst_n so nothing looks acceptable while in reset.
   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign a_arr[g]     = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g]     = req_b[g*WIDTH +: WIDTH];
      assign req_ready[g] = rst_n && (state == S_IDLE) && sel_vld && (sel == IDW'(g));
      assign rsp_valid[g] = (state == S_RESP) && (grant_id == IDW'(g));
   end

   // Round-robin: first valid requester searching from ptr+1, wrapping.
   always_comb begin
      logic [IDW-1:0] idx;
      sel     = '0;
      sel_vld = 1'b0;
      idx     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDW'((int'(ptr) + k) % N_REQ);
         if (!sel_vld && req_valid[idx]) begin
            sel_vld = 1'b1;
            sel     = idx;
         end
      end
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= IDW'(N_REQ - 1);
         cnt      <= '0;
         grant_id <= '0;
         dp_go    <= 1'b0;
         dp_in0   <= '0;
         dp_in1   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // sel_vld implies req_valid[sel] & req_ready[sel]: a handshake.
               if (sel_vld) begin
                  dp_in0   <= a_arr[sel];
                  dp_in1   <= b_arr[sel];
                  grant_id <= sel;
                  ptr      <= sel;
                  dp_go    <= 1'b1;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               dp_go <= 1'b0;
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // done is checked first so it wins on the last watchdog cycle
               if (dp_done) begin
                  rsp_data <= dp_result;
                  rsp_err  <= 1'b0;
                  state    <= S_RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                  state    <= S_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready[grant_id]) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alap_dp_arbiter.sv
module tb_alap_dp_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   rsp_data, dp_in0, dp_in1, dp_result;
   logic           rsp_err, dp_go, dp_done, busy;
   logic [1:0]     grant_id;

   int n_err = 0;
   int n_chk = 0;

   // datapath model: done 'lat' cycles after the go cycle; lat=0 means never
   int          lat = 9;
   int          mcnt = 0;
   logic        armed = 1'b0;
   logic [W-1:0] dp_res = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dp_go) begin
         armed <= 1'b1;
         mcnt  <= 1;
      end else if (armed) begin
         if (dp_done) armed <= 1'b0;
         mcnt <= mcnt + 1;
      end
   end
   assign dp_done   = armed && (lat != 0) && (mcnt == lat);
   assign dp_result = dp_res;

   alap_dp_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .dp_go(dp_go), .dp_in0(dp_in0), .dp_in1(dp_in1),
      .dp_done(dp_done), .dp_result(dp_result),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_go();
      int i = 0;
      while (!dp_go && i < 200) begin @(negedge clk); i++; end
      chk("go_seen", {31'd0, dp_go}, 1);
   endtask

   task automatic wait_rsp();
      int i = 0;
      while (rsp_valid == '0 && i < 200) begin @(negedge clk); i++; end
      chk("rsp_seen", {31'd0, |rsp_valid}, 1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 200) begin @(negedge clk); i++; end
      chk("idle_seen", {31'd0, busy}, 0);
   endtask

   // count WAIT cycles from the first WAIT negedge until RESP
   task automatic count_wait(output int n);
      n = 0;
      while (busy && rsp_valid == '0 && n < 100) begin n++; @(negedge clk); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_req_ready", {28'd0, req_ready}, 0);
      chk("rst_rsp_valid", {28'd0, rsp_valid}, 0);
      chk("rst_dp_go", {31'd0, dp_go}, 0);
      chk("rst_dp_in0", dp_in0, 0);
      chk("rst_dp_in1", dp_in1, 0);
      chk("rst_grant", {30'd0, grant_id}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single request from requester 2, 12-cycle op
      rsp_ready = '1;
      lat = 9; dp_res = 32'h4040_0000;
      req_a[2*W +: W] = 32'h3F80_0000;
      req_b[2*W +: W] = 32'h4000_0000;
      req_valid = 4'b0100;
      #1 chk("t1_req_ready", {28'd0, req_ready}, 32'h4);
      @(negedge clk);
      chk("t1_go", {31'd0, dp_go}, 1);
      chk("t1_ready_off", {28'd0, req_ready}, 0);
      chk("t1_grant", {30'd0, grant_id}, 2);
      chk("t1_in0", dp_in0, 32'h3F80_0000);
      chk("t1_in1", dp_in1, 32'h4000_0000);
      req_valid = '0;
      @(negedge clk);
      chk("t1_go_pulse", {31'd0, dp_go}, 0);
      cyc = 2;
      while (!rsp_valid[2] && cyc < 40) begin @(negedge clk); cyc++; end
      chk("t1_rsp_cycle", cyc, 11);
      chk("t1_rsp_valid", {28'd0, rsp_valid}, 32'h4);
      chk("t1_rsp_data", rsp_data, 32'h4040_0000);
      chk("t1_rsp_err", {31'd0, rsp_err}, 0);
      @(negedge clk);
      chk("t1_idle_at_12", {31'd0, busy}, 0);

      // all requesters valid from reset: grants 0,1,2,3,0
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = 32'h100 + i;
         req_b[i*W +: W] = 32'h200 + i;
      end
      req_valid = 4'b1111;
      #1 chk("t2_ready_in_rst", {28'd0, req_ready}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         wait_go();
         chk("t2_grant", {30'd0, grant_id}, g % N);
         chk("t2_in0", dp_in0, 32'h100 + (g % N));
         if (g == 4) req_valid = '0;
         @(negedge clk);
      end
      wait_idle();

      // watchdog timeout, then a normal op
      lat = 0;
      req_valid = 4'b0010;
      wait_go();
      req_valid = '0;
      chk("t3_grant", {30'd0, grant_id}, 1);
      @(negedge clk);
      count_wait(cyc);
      chk("t3_wait_cycles", cyc, 16);
      chk("t3_rsp_valid", {28'd0, rsp_valid}, 32'h2);
      chk("t3_rsp_err", {31'd0, rsp_err}, 1);
      chk("t3_rsp_data", rsp_data, 0);
      @(negedge clk);
      lat = 9; dp_res = 32'hCAFE_0001;
      req_valid = 4'b1000;
      wait_go();
      req_valid = '0;
      wait_rsp();
      chk("t3b_rsp_valid", {28'd0, rsp_valid}, 32'h8);
      chk("t3b_rsp_err", {31'd0, rsp_err}, 0);
      chk("t3b_rsp_data", rsp_data, 32'hCAFE_0001);
      @(negedge clk);

      // response back-pressure with a competing request
      rsp_ready = '0;
      dp_res = 32'h1234_5678;
      req_valid = 4'b0001;
      wait_go();
      req_valid = '0;
      wait_rsp();
      req_valid = 4'b0010;
      rsp_ready = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", {28'd0, rsp_valid}, 32'h1);
         chk("t4_hold_data", rsp_data, 32'h1234_5678);
         chk("t4_no_ready", {28'd0, req_ready}, 0);
         @(negedge clk);
      end
      rsp_ready = 4'b0001;
      @(negedge clk);
      chk("t4_idle", {31'd0, busy}, 0);
      chk("t4_next_ready", {28'd0, req_ready}, 32'h2);
      rsp_ready = '1;
      wait_go();
      chk("t4_grant1", {30'd0, grant_id}, 1);
      req_valid = '0;
      wait_idle();

      // reset during WAIT
      dp_res = 32'hDEAD_BEEF;
      req_valid = 4'b0100;
      wait_go();
      req_valid = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", {31'd0, busy}, 0);
      chk("t5_go", {31'd0, dp_go}, 0);
      chk("t5_in0", dp_in0, 0);
      chk("t5_grant", {30'd0, grant_id}, 0);
      chk("t5_rsp_valid", {28'd0, rsp_valid}, 0);
      chk("t5_rsp_data", rsp_data, 0);
      chk("t5_rsp_err", {31'd0, rsp_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_done_ignored", {27'd0, busy, rsp_valid}, 0);
      end
      req_valid = 4'b1001;
      #1 chk("t5_first_ready", {28'd0, req_ready}, 32'h1);
      @(negedge clk);
      chk("t5_first_grant", {30'd0, grant_id}, 0);
      req_valid = '0;
      wait_idle();

      // done on the final watchdog cycle wins
      lat = 16; dp_res = 32'h0BAD_F00D;
      req_valid = 4'b1000;
      wait_go();
      req_valid = '0;
      @(negedge clk);
      count_wait(cyc);
      chk("t6_wait_cycles", cyc, 16);
      chk("t6_rsp_err", {31'd0, rsp_err}, 0);
      chk("t6_rsp_data", rsp_data, 32'h0BAD_F00D);
      @(negedge clk);

      // one cycle later is a timeout
      lat = 17;
      req_valid = 4'b0010;
      wait_go();
      req_valid = '0;
      @(negedge clk);
      count_wait(cyc);
      chk("t7_wait_cycles", cyc, 16);
      chk("t7_rsp_err", {31'd0, rsp_err}, 1);
      chk("t7_rsp_data", rsp_data, 0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
